// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the LC-3 memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BE_W   = DATA_W / 8;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } arb_state_e;

    // One latched memory request.
    typedef struct packed {
        logic              read;
        logic              write;
        logic [BE_W-1:0]   byte_enable;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Build a request from client strobes. A client raising read and write
    // together is forwarded as a write only.
    function automatic mem_req_t make_req(
        input logic              rd,
        input logic              wr,
        input logic [BE_W-1:0]   be,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        mem_req_t req;
        req.read        = rd & ~wr;
        req.write       = wr;
        req.byte_enable = be;
        req.address     = addr;
        req.wdata       = wdata;
        return req;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-client (instruction fetch / data) arbiter onto one single-port memory.
// Data client has priority; after a D access a pending I access goes first,
// so neither client can starve the other.
// The request register is a mem_arb_pkg::mem_req_t, so overriding the width
// parameters requires the package widths to match.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction-fetch client
    input  logic              i_read,
    input  logic              i_write,
    input  logic [BE_W-1:0]   i_byte_enable,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    // data client
    input  logic              d_read,
    input  logic              d_write,
    input  logic [BE_W-1:0]   d_byte_enable,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              m_read,
    output logic              m_write,
    output logic [BE_W-1:0]   m_byte_enable,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_resp,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    mem_req_t          r_req;
    mem_req_t          w_req_next;
    mem_req_t          w_req_i;
    mem_req_t          w_req_d;
    logic              w_pend_i;
    logic              w_pend_d;
    logic              w_serve_next;
    logic              r_last_d;

    logic              r_m_read;
    logic              r_m_write;
    logic [BE_W-1:0]   r_m_byte_enable;
    logic [ADDR_W-1:0] r_m_address;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_i_resp;
    logic              r_d_resp;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    // Next-state, grant decision and request-register load.
    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_pend_i     = i_read | i_write;
        w_pend_d     = d_read | d_write;
        w_req_i      = make_req(i_read, i_write, i_byte_enable, i_address, i_wdata);
        w_req_d      = make_req(d_read, d_write, d_byte_enable, d_address, d_wdata);
        case (r_state)
            IDLE: begin
                if (w_pend_d && !(w_pend_i && r_last_d)) begin
                    w_state_next = SERVE_D;
                    w_req_next   = w_req_d;
                end else if (w_pend_i) begin
                    w_state_next = SERVE_I;
                    w_req_next   = w_req_i;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SERVE_I: begin
                if (m_resp) begin
                    w_state_next = RESP_I;
                end else begin
                    w_state_next = SERVE_I;
                end
            end
            SERVE_D: begin
                if (m_resp) begin
                    w_state_next = RESP_D;
                end else begin
                    w_state_next = SERVE_D;
                end
            end
            RESP_I:  w_state_next = IDLE;
            RESP_D:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_serve_next = (w_state_next == SERVE_I) || (w_state_next == SERVE_D);
    end

    // State, request register and registered memory-side / response strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_req           <= '0;
            r_m_read        <= 1'b0;
            r_m_write       <= 1'b0;
            r_m_byte_enable <= {BE_W{1'b0}};
            r_m_address     <= {ADDR_W{1'b0}};
            r_m_wdata       <= {DATA_W{1'b0}};
            r_i_resp        <= 1'b0;
            r_d_resp        <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_req           <= w_req_next;
            r_m_read        <= w_serve_next & w_req_next.read;
            r_m_write       <= w_serve_next & w_req_next.write;
            r_m_byte_enable <= w_serve_next ? w_req_next.byte_enable : {BE_W{1'b0}};
            r_m_address     <= w_serve_next ? w_req_next.address : {ADDR_W{1'b0}};
            r_m_wdata       <= w_serve_next ? w_req_next.wdata : {DATA_W{1'b0}};
            r_i_resp        <= (w_state_next == RESP_I);
            r_d_resp        <= (w_state_next == RESP_D);
        end
    end

    // Fairness bit: remembers which client completed most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (m_resp && (r_state == SERVE_D)) begin
            r_last_d <= 1'b1;
        end else if (m_resp && (r_state == SERVE_I)) begin
            r_last_d <= 1'b0;
        end else begin
            r_last_d <= r_last_d;
        end
    end

    // Read-data capture; each client's value holds until its next read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rdata <= {DATA_W{1'b0}};
            r_d_rdata <= {DATA_W{1'b0}};
        end else if (m_resp && r_req.read && (r_state == SERVE_I)) begin
            r_i_rdata <= m_rdata;
        end else if (m_resp && r_req.read && (r_state == SERVE_D)) begin
            r_d_rdata <= m_rdata;
        end else begin
            r_i_rdata <= r_i_rdata;
            r_d_rdata <= r_d_rdata;
        end
    end

    assign m_read        = r_m_read;
    assign m_write       = r_m_write;
    assign m_byte_enable = r_m_byte_enable;
    assign m_address     = r_m_address;
    assign m_wdata       = r_m_wdata;
    assign i_resp        = r_i_resp;
    assign d_resp        = r_d_resp;
    assign i_rdata       = r_i_rdata;
    assign d_rdata       = r_d_rdata;

endmodule
